// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the raster timing generator:
//   vga_timing_t      - one complete mode description (all fields in pixels/lines)
//   VGA_640x480_60    - standard 640x480@60 mode (25 MHz pixel rate)
//   VGA_320x240_TEST  - reduced mode for fast bring-up / simulation
//   vga_sync_pol_e    - sync pulse active level
// ---------------------------------------------------------------------------
package vga_pkg;

   typedef struct packed {
      logic [15:0] h_active;
      logic [15:0] h_fp;
      logic [15:0] h_sync;
      logic [15:0] h_bp;
      logic [15:0] v_active;
      logic [15:0] v_fp;
      logic [15:0] v_sync;
      logic [15:0] v_bp;
   } vga_timing_t;

   localparam vga_timing_t VGA_640x480_60 = '{
      h_active : 16'd640, h_fp : 16'd16, h_sync : 16'd96, h_bp : 16'd48,
      v_active : 16'd480, v_fp : 16'd10, v_sync : 16'd2,  v_bp : 16'd33
   };

   localparam vga_timing_t VGA_320x240_TEST = '{
      h_active : 16'd320, h_fp : 16'd8, h_sync : 16'd32, h_bp : 16'd40,
      v_active : 16'd240, v_fp : 16'd5, v_sync : 16'd2,  v_bp : 16'd15
   };

   typedef enum logic {
      SYNC_ACTIVE_LOW  = 1'b0,
      SYNC_ACTIVE_HIGH = 1'b1
   } vga_sync_pol_e;

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a 0..TOTAL-1 counter that advances on adv and wraps
// exactly, plus combinational decode of the current count.
//   clk, rst  - system clock, synchronous active-high reset (count -> 0)
//   adv       - advance the counter by one this clock
//   count     - current position, W bits
//   wrap      - count is at TOTAL-1 (next advance returns to 0)
//   active    - count is inside the visible region (count < ACTIVE)
//   sync      - sync level for this count, already at polarity POL
// ---------------------------------------------------------------------------
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL  = 800,
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter bit POL    = 1'b0,
   localparam int W     = $clog2(TOTAL)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         adv,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         active,
   output logic         sync
);

   localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
   // Back porch is at least one unit, so this bound is <= TOTAL-1 and fits in W.
   localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);
   localparam vga_sync_pol_e POL_E  = vga_sync_pol_e'(POL);

   logic in_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (adv) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

   assign wrap    = (count == LAST);
   assign active  = (count < ACT_END);
   assign in_sync = (count >= SYNC_LO) && (count < SYNC_HI);
   assign sync    = (POL_E == SYNC_ACTIVE_HIGH) ? in_sync : ~in_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator running on the system clock with an
// internal pixel-enable divider (no derived pixel clock).
//   clk          - system clock
//   rst          - synchronous, active-high reset
//   pix_en       - one-clock strobe; every other output changes only in the
//                  cycle pix_en is high and holds otherwise, so consumers
//                  qualify the event strobes with pix_en
//   h_sync       - horizontal sync at H_POL level
//   v_sync       - vertical sync at V_POL level
//   de           - display enable (visible area)
//   x, y         - raster position 0..H_TOTAL-1 / 0..V_TOTAL-1
//   line_start   - pixel with x==0
//   frame_start  - pixel with x==0, y==0
//   vblank_start - pixel with x==0, y==V_ACTIVE (game-logic tick)
//   frame_cnt    - frames started since reset; only counts when the
//                  VGA_FRAME_CNT_EN macro is defined, otherwise tied to 0
// Outputs lag the internal pixel tick by one clock.
// ---------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = int'(VGA_640x480_60.h_active),
   parameter int H_FP     = int'(VGA_640x480_60.h_fp),
   parameter int H_SYNC   = int'(VGA_640x480_60.h_sync),
   parameter int H_BP     = int'(VGA_640x480_60.h_bp),
   parameter int V_ACTIVE = int'(VGA_640x480_60.v_active),
   parameter int V_FP     = int'(VGA_640x480_60.v_fp),
   parameter int V_SYNC   = int'(VGA_640x480_60.v_sync),
   parameter int V_BP     = int'(VGA_640x480_60.v_bp),
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW      = $clog2(H_TOTAL),
   localparam int YW      = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          pix_en,
   output logic          h_sync,
   output logic          v_sync,
   output logic          de,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic          vblank_start,
   output logic [15:0]   frame_cnt
);

   generate
      if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
          V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
         $error("vga_timing_gen: CLK_DIV and all H_*/V_* timing parameters must be >= 1");
      end
   endgenerate

   // ---------------- pixel-enable divider ----------------
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic          pix_tick;

   // With CLK_DIV=1 div_cnt stays 0 and pix_tick is permanently high.
   assign pix_tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= pix_tick ? '0 : div_cnt + 1'b1;
      end
   end

   // ---------------- axis counters ----------------
   logic [XW-1:0] h_cnt;
   logic [YW-1:0] v_cnt;
   logic          h_wrap, h_active, h_sync_dec;
   logic          v_active, v_sync_dec;
   // Frame wrap is already implied by the (0,0) decode, so nothing reads it.
   logic          v_wrap_unused;

   vga_axis_counter #(
      .TOTAL (H_TOTAL),
      .ACTIVE(H_ACTIVE),
      .FP    (H_FP),
      .SYNC  (H_SYNC),
      .POL   (H_POL)
   ) u_h_axis (
      .clk   (clk),
      .rst   (rst),
      .adv   (pix_tick),
      .count (h_cnt),
      .wrap  (h_wrap),
      .active(h_active),
      .sync  (h_sync_dec)
   );

   // The vertical axis moves only on the last pixel of a line, so its sync
   // decode can only change together with the h==0 boundary.
   vga_axis_counter #(
      .TOTAL (V_TOTAL),
      .ACTIVE(V_ACTIVE),
      .FP    (V_FP),
      .SYNC  (V_SYNC),
      .POL   (V_POL)
   ) u_v_axis (
      .clk   (clk),
      .rst   (rst),
      .adv   (pix_tick & h_wrap),
      .count (v_cnt),
      .wrap  (v_wrap_unused),
      .active(v_active),
      .sync  (v_sync_dec)
   );

   // ---------------- decode ----------------
   localparam logic [YW-1:0] V_VBL = YW'(V_ACTIVE);

   logic h_zero, v_zero, v_vbl;

   assign h_zero = (h_cnt == '0);
   assign v_zero = (v_cnt == '0);
   assign v_vbl  = (v_cnt == V_VBL);

   // ---------------- output register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_en       <= 1'b0;
         h_sync       <= ~H_POL;
         v_sync       <= ~V_POL;
         de           <= 1'b0;
         x            <= '0;
         y            <= '0;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
      end else begin
         pix_en <= pix_tick;
         if (pix_tick) begin
            h_sync       <= h_sync_dec;
            v_sync       <= v_sync_dec;
            de           <= h_active & v_active;
            x            <= h_cnt;
            y            <= v_cnt;
            line_start   <= h_zero;
            frame_start  <= h_zero & v_zero;
            vblank_start <= h_zero & v_vbl;
         end
      end
   end

   // ---------------- optional frame counter ----------------
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   // Counts on the same tick that registers frame_start, so the first frame
   // after reset already shows 1. Wraps naturally at 16'hFFFF.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= 16'd0;
      end else if (pix_tick && h_zero && v_zero) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Two instances share one clock:
//   dut   - default 640x480 mode, CLK_DIV=2
//   dut_s - tiny mode H 8/2/3/1, V 4/1/1/1, CLK_DIV=1, active-high hsync
// Expected values are hand-derived from the mode tables.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst   = 1'b1;
   logic rst_s = 1'b1;

   // ---------------- default instance ----------------
   logic        d_pix_en, d_h_sync, d_v_sync, d_de;
   logic [9:0]  d_x;
   logic [9:0]  d_y;
   logic        d_line_start, d_frame_start, d_vblank_start;
   logic [15:0] d_frame_cnt;

   vga_timing_gen dut (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (d_pix_en),
      .h_sync      (d_h_sync),
      .v_sync      (d_v_sync),
      .de          (d_de),
      .x           (d_x),
      .y           (d_y),
      .line_start  (d_line_start),
      .frame_start (d_frame_start),
      .vblank_start(d_vblank_start),
      .frame_cnt   (d_frame_cnt)
   );

   // ---------------- small instance ----------------
   logic        s_pix_en, s_h_sync, s_v_sync, s_de;
   logic [3:0]  s_x;
   logic [2:0]  s_y;
   logic        s_line_start, s_frame_start, s_vblank_start;
   logic [15:0] s_frame_cnt;

   vga_timing_gen #(
      .CLK_DIV (1),
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL   (1'b1),
      .V_POL   (1'b0)
   ) dut_s (
      .clk         (clk),
      .rst         (rst_s),
      .pix_en      (s_pix_en),
      .h_sync      (s_h_sync),
      .v_sync      (s_v_sync),
      .de          (s_de),
      .x           (s_x),
      .y           (s_y),
      .line_start  (s_line_start),
      .frame_start (s_frame_start),
      .vblank_start(s_vblank_start),
      .frame_cnt   (s_frame_cnt)
   );

   // ---------------- scoreboard counters ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance to the next default-instance pixel; clks returns how many
   // clocks it took (bounded, so a dead pix_en shows up as a wrong gap).
   task automatic next_pix_d(output int clks);
      clks = 0;
      do begin
         step();
         clks++;
      end while (d_pix_en !== 1'b1 && clks < 8);
   endtask

   // Line statistics for the default instance, starting at x==0 already shown.
   int gap_err, x_err, y_err, ls_err, hs_low, hs_first, hs_last, de_low, de_first;

   task automatic scan_line_d(input int exp_y);
      int c;
      gap_err = 0; x_err = 0; y_err = 0; ls_err = 0;
      hs_low = 0; hs_first = -1; hs_last = -1; de_low = 0; de_first = -1;
      for (int t = 0; t < 800; t++) begin
         if (t > 0) begin
            next_pix_d(c);
            if (c != 2) gap_err++;
         end
         if (int'(d_x) != t) x_err++;
         if (int'(d_y) != exp_y) y_err++;
         if (d_line_start !== (t == 0)) ls_err++;
         if (d_h_sync === 1'b0) begin
            hs_low++;
            if (hs_first < 0) hs_first = t;
            hs_last = t;
         end
         if (d_de === 1'b0) begin
            de_low++;
            if (de_first < 0) de_first = t;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   int c;
   int pe_err, xy_err, de_err, hs_err, vs_err, lse_err, fs_err, vb_err, fc_err;
   int hs_hi, vs_lo, fs_cnt, fs_second, vb_cnt, vb_first;

   initial begin
      // ---- reset held 3 clocks ----
      repeat (3) step();
      check("d_rst_pix_en",  d_pix_en, 0);
      check("d_rst_x",       d_x, 0);
      check("d_rst_y",       d_y, 0);
      check("d_rst_de",      d_de, 0);
      check("d_rst_ls",      d_line_start, 0);
      check("d_rst_fs",      d_frame_start, 0);
      check("d_rst_vb",      d_vblank_start, 0);
      check("d_rst_hsync",   d_h_sync, 1);
      check("d_rst_vsync",   d_v_sync, 1);
      check("d_rst_fcnt",    d_frame_cnt, 0);
      check("s_rst_pix_en",  s_pix_en, 0);
      check("s_rst_hsync",   s_h_sync, 0);
      check("s_rst_vsync",   s_v_sync, 1);

      // ---- release: first pixel appears on the second clock ----
      rst = 1'b0;
      step();
      check("d_clk1_pix_en", d_pix_en, 0);
      step();
      check("d_first_pix_en", d_pix_en, 1);
      check("d_first_x",      d_x, 0);
      check("d_first_y",      d_y, 0);
      check("d_first_de",     d_de, 1);
      check("d_first_fs",     d_frame_start, 1);
      check("d_first_ls",     d_line_start, 1);
      check("d_first_vb",     d_vblank_start, 0);
      check("d_first_hsync",  d_h_sync, 1);
      check("d_first_vsync",  d_v_sync, 1);

      // ---- one full line y=0 ----
      scan_line_d(0);
      check("d_l0_gap",      gap_err, 0);
      check("d_l0_x_seq",    x_err, 0);
      check("d_l0_y",        y_err, 0);
      check("d_l0_ls",       ls_err, 0);
      check("d_l0_hs_low",   hs_low, 96);
      check("d_l0_hs_first", hs_first, 656);
      check("d_l0_hs_last",  hs_last, 751);
      check("d_l0_de_low",   de_low, 160);
      check("d_l0_de_first", de_first, 640);

      // ---- wrap 799 -> 0, next line ----
      next_pix_d(c);
      check("d_wrap_gap",   c, 2);
      check("d_wrap_x",     d_x, 0);
      check("d_wrap_y",     d_y, 1);
      check("d_wrap_ls",    d_line_start, 1);
      check("d_wrap_fs",    d_frame_start, 0);
      check("d_wrap_de",    d_de, 1);
      check("d_wrap_vsync", d_v_sync, 1);

      // ---- run into the hsync pulse at x=700, then reset for one clock ----
      for (int t = 1; t <= 700; t++) next_pix_d(c);
      check("d_mid_x",     d_x, 700);
      check("d_mid_y",     d_y, 1);
      check("d_mid_hsync", d_h_sync, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("d_mrst_pix_en", d_pix_en, 0);
      check("d_mrst_x",      d_x, 0);
      check("d_mrst_y",      d_y, 0);
      check("d_mrst_de",     d_de, 0);
      check("d_mrst_hsync",  d_h_sync, 1);
      check("d_mrst_fs",     d_frame_start, 0);
      next_pix_d(c);
      check("d_restart_lat", c, 2);
      check("d_restart_x",   d_x, 0);
      check("d_restart_y",   d_y, 0);
      check("d_restart_fs",  d_frame_start, 1);
      check("d_restart_hs",  d_h_sync, 1);
      scan_line_d(0);
      check("d_r_gap",      gap_err, 0);
      check("d_r_x_seq",    x_err, 0);
      check("d_r_hs_low",   hs_low, 96);
      check("d_r_hs_first", hs_first, 656);

      // ---- small mode: two full frames, tick model x=t%14, y=(t/14)%7 ----
      rst_s = 1'b0;
      step();
      check("s_first_pix_en", s_pix_en, 1);
      check("s_first_fs",     s_frame_start, 1);
      check("s_first_de",     s_de, 1);
      check("s_first_hsync",  s_h_sync, 0);
      pe_err = 0; xy_err = 0; de_err = 0; hs_err = 0; vs_err = 0;
      lse_err = 0; fs_err = 0; vb_err = 0; fc_err = 0;
      hs_hi = 0; vs_lo = 0; fs_cnt = 0; fs_second = -1; vb_cnt = 0; vb_first = -1;
      for (int t = 0; t < 196; t++) begin
         int ex, ey;
         logic [15:0] exp_fc;
         if (t > 0) step();
         ex = t % 14;
         ey = (t / 14) % 7;
`ifdef VGA_FRAME_CNT_EN
         exp_fc = 16'(t / 98 + 1);
`else
         exp_fc = 16'd0;
`endif
         if (s_pix_en !== 1'b1) pe_err++;
         if (int'(s_x) != ex || int'(s_y) != ey) xy_err++;
         if (s_de !== (ex < 8 && ey < 4)) de_err++;
         if (s_h_sync !== (ex >= 10 && ex <= 12)) hs_err++;
         if (s_v_sync !== (ey != 5)) vs_err++;
         if (s_line_start !== (ex == 0)) lse_err++;
         if (s_frame_start !== (ex == 0 && ey == 0)) fs_err++;
         if (s_vblank_start !== (ex == 0 && ey == 4)) vb_err++;
         if (s_frame_cnt !== exp_fc) fc_err++;
         if (s_h_sync === 1'b1) hs_hi++;
         if (s_v_sync === 1'b0) vs_lo++;
         if (s_frame_start === 1'b1) begin
            fs_cnt++;
            if (fs_cnt == 2) fs_second = t;
         end
         if (s_vblank_start === 1'b1) begin
            vb_cnt++;
            if (vb_first < 0) vb_first = t;
         end
      end
      check("s_pix_en_const", pe_err, 0);
      check("s_xy_seq",       xy_err, 0);
      check("s_de",           de_err, 0);
      check("s_hsync",        hs_err, 0);
      check("s_vsync",        vs_err, 0);
      check("s_ls",           lse_err, 0);
      check("s_fs",           fs_err, 0);
      check("s_vb",           vb_err, 0);
      check("s_fcnt",         fc_err, 0);
      check("s_hs_hi_cnt",    hs_hi, 42);
      check("s_vs_lo_cnt",    vs_lo, 28);
      check("s_fs_cnt",       fs_cnt, 2);
      check("s_frame_period", fs_second, 98);
      check("s_vb_cnt",       vb_cnt, 2);
      check("s_vb_first",     vb_first, 56);

      // ---- small mode: reset in the middle of both sync pulses ----
      repeat (82) step();
      check("s_mid_x",     s_x, 11);
      check("s_mid_y",     s_y, 5);
      check("s_mid_hsync", s_h_sync, 1);
      check("s_mid_vsync", s_v_sync, 0);
      rst_s = 1'b1;
      step();
      rst_s = 1'b0;
      check("s_mrst_pix_en", s_pix_en, 0);
      check("s_mrst_hsync",  s_h_sync, 0);
      check("s_mrst_vsync",  s_v_sync, 1);
      check("s_mrst_x",      s_x, 0);
      check("s_mrst_de",     s_de, 0);
      check("s_mrst_fcnt",   s_frame_cnt, 0);
      step();
      check("s_restart_pix_en", s_pix_en, 1);
      check("s_restart_x",      s_x, 0);
      check("s_restart_y",      s_y, 0);
      check("s_restart_fs",     s_frame_start, 1);
      check("s_restart_hsync",  s_h_sync, 0);
      check("s_restart_vsync",  s_v_sync, 1);

      // ---- frame counter ----
`ifdef VGA_FRAME_CNT_EN
      check("s_fcnt_first", s_frame_cnt, 1);
      repeat (90) step();
      force dut_s.frame_cnt_q = 16'hFFFF;
      step();
      release dut_s.frame_cnt_q;
      check("s_fcnt_preload", s_frame_cnt, 16'hFFFF);
      repeat (7) step();
      check("s_fcnt_wrap_fs", s_frame_start, 1);
      check("s_fcnt_wrap",    s_frame_cnt, 0);
`else
      check("s_fcnt_first", s_frame_cnt, 0);
      repeat (98) step();
      check("s_fcnt_next_fs", s_frame_start, 1);
      check("s_fcnt_next",    s_frame_cnt, 0);
      check("d_fcnt_tied",    d_frame_cnt, 0);
`endif

      // ---- final report ----
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog: the directed sequence needs well under 10k clocks.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected sequence completion");
      $fatal(1, "watchdog expired");
   end

endmodule
